// File: rtl/mc_pkg.sv
//==============================================================================
// Module : mc_pkg
// Brief  : Shared encodings for the multicycle RV32I control FSM.
//          The HALT state exists only when ILLEGAL_TRAP_EN is defined.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t C_ST_FETCH    = 4'd0;
    localparam state_t C_ST_DECODE   = 4'd1;
    localparam state_t C_ST_MEMADR   = 4'd2;
    localparam state_t C_ST_MEMREAD  = 4'd3;
    localparam state_t C_ST_MEMWB    = 4'd4;
    localparam state_t C_ST_MEMWRITE = 4'd5;
    localparam state_t C_ST_EXECUTER = 4'd6;
    localparam state_t C_ST_EXECUTEI = 4'd7;
    localparam state_t C_ST_ALUWB    = 4'd8;
    localparam state_t C_ST_BRANCH   = 4'd9;
    localparam state_t C_ST_JAL      = 4'd10;
`ifdef ILLEGAL_TRAP_EN
    localparam state_t C_ST_HALT     = 4'd11;
`endif

    localparam logic [2:0] C_ALU_ADD = 3'b000;
    localparam logic [2:0] C_ALU_SUB = 3'b001;
    localparam logic [2:0] C_ALU_AND = 3'b010;
    localparam logic [2:0] C_ALU_OR  = 3'b011;
    localparam logic [2:0] C_ALU_XOR = 3'b100;
    localparam logic [2:0] C_ALU_SLT = 3'b101;

    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] C_RES_ALUOUT    = 2'b00;
    localparam logic [1:0] C_RES_DATA      = 2'b01;
    localparam logic [1:0] C_RES_ALURESULT = 2'b10;

    localparam logic [1:0] C_SRCA_PC    = 2'b00;
    localparam logic [1:0] C_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] C_SRCA_RS1   = 2'b10;

    localparam logic [1:0] C_SRCB_RS2  = 2'b00;
    localparam logic [1:0] C_SRCB_IMM  = 2'b01;
    localparam logic [1:0] C_SRCB_FOUR = 2'b10;

    localparam logic [1:0] C_IMM_I = 2'b00;
    localparam logic [1:0] C_IMM_S = 2'b01;
    localparam logic [1:0] C_IMM_B = 2'b10;
    localparam logic [1:0] C_IMM_J = 2'b11;

    localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OP_STORE  = 7'b0100011;
    localparam logic [6:0] C_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] C_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] C_OP_JAL    = 7'b1101111;

    // States whose exit back to FETCH completes an instruction.
    function automatic logic is_retire_state(input state_t s);
        return (s == C_ST_MEMWB) || (s == C_ST_MEMWRITE) ||
               (s == C_ST_ALUWB) || (s == C_ST_BRANCH);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
//==============================================================================
// Module : alu_decoder
// Brief  : Maps ALUOp plus instruction fields to the ALUControl code.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module alu_decoder
    import mc_pkg::*;
(
    input  logic       op5_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    input  logic [1:0] aluop_i,
    output logic [2:0] alucontrol_o
);

    always_comb begin
        alucontrol_o = C_ALU_ADD;
        case (aluop_i)
            C_ALUOP_ADD: alucontrol_o = C_ALU_ADD;
            C_ALUOP_SUB: alucontrol_o = C_ALU_SUB;
            default: begin
                case (funct3_i)
                    // Only R-type uses funct7b5; addi with imm[10] set stays add.
                    3'b000:  alucontrol_o = (funct7b5_i & op5_i) ? C_ALU_SUB : C_ALU_ADD;
                    3'b010:  alucontrol_o = C_ALU_SLT;
                    3'b110:  alucontrol_o = C_ALU_OR;
                    3'b111:  alucontrol_o = C_ALU_AND;
                    3'b100:  alucontrol_o = C_ALU_XOR;
                    default: alucontrol_o = C_ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
//==============================================================================
// Module : multicycle_ctrl
// Brief  : Moore control FSM for a multicycle RV32I datapath, with a
//          retired-instruction counter. Define ILLEGAL_TRAP_EN to halt on
//          undecoded opcodes instead of skipping them as NOPs.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             Illegal,
    output logic [CNT_W-1:0] InstRet
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [1:0]       w_aluop;

    alu_decoder u_alu_decoder (
        .op5_i        (op[5]),
        .funct3_i     (funct3),
        .funct7b5_i   (funct7b5),
        .aluop_i      (w_aluop),
        .alucontrol_o (ALUControl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_FETCH:  state_d = C_ST_DECODE;
            C_ST_DECODE: begin
                case (op)
                    C_OP_LOAD,
                    C_OP_STORE:  state_d = C_ST_MEMADR;
                    C_OP_RTYPE:  state_d = C_ST_EXECUTER;
                    C_OP_ITYPE:  state_d = C_ST_EXECUTEI;
                    C_OP_BRANCH: state_d = C_ST_BRANCH;
                    C_OP_JAL:    state_d = C_ST_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:     state_d = C_ST_HALT;
`else
                    default:     state_d = C_ST_FETCH;
`endif
                endcase
            end
            C_ST_MEMADR:   state_d = op[5] ? C_ST_MEMWRITE : C_ST_MEMREAD;
            C_ST_MEMREAD:  state_d = C_ST_MEMWB;
            C_ST_MEMWB:    state_d = C_ST_FETCH;
            C_ST_MEMWRITE: state_d = C_ST_FETCH;
            C_ST_EXECUTER: state_d = C_ST_ALUWB;
            C_ST_EXECUTEI: state_d = C_ST_ALUWB;
            C_ST_ALUWB:    state_d = C_ST_FETCH;
            C_ST_BRANCH:   state_d = C_ST_FETCH;
            C_ST_JAL:      state_d = C_ST_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            C_ST_HALT:     state_d = C_ST_HALT;
`endif
            default:       state_d = C_ST_FETCH;
        endcase
    end

    always_comb begin
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        Illegal   = 1'b0;
        ResultSrc = C_RES_ALUOUT;
        ALUSrcA   = C_SRCA_PC;
        ALUSrcB   = C_SRCB_RS2;
        ImmSrc    = C_IMM_I;
        w_aluop   = C_ALUOP_ADD;
        case (state_q)
            C_ST_FETCH: begin
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcB   = C_SRCB_FOUR;
                ResultSrc = C_RES_ALURESULT;
            end
            C_ST_DECODE: begin
                ALUSrcA = C_SRCA_OLDPC;
                ALUSrcB = C_SRCB_IMM;
                ImmSrc  = C_IMM_B;
            end
            C_ST_MEMADR: begin
                ALUSrcA = C_SRCA_RS1;
                ALUSrcB = C_SRCB_IMM;
                ImmSrc  = op[5] ? C_IMM_S : C_IMM_I;
            end
            C_ST_MEMREAD:  AdrSrc = 1'b1;
            C_ST_MEMWB: begin
                ResultSrc = C_RES_DATA;
                RegWrite  = 1'b1;
            end
            C_ST_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            C_ST_EXECUTER: begin
                ALUSrcA = C_SRCA_RS1;
                w_aluop = C_ALUOP_FUNCT;
            end
            C_ST_EXECUTEI: begin
                ALUSrcA = C_SRCA_RS1;
                ALUSrcB = C_SRCB_IMM;
                w_aluop = C_ALUOP_FUNCT;
            end
            C_ST_ALUWB:    RegWrite = 1'b1;
            C_ST_BRANCH: begin
                ALUSrcA = C_SRCA_RS1;
                w_aluop = C_ALUOP_SUB;
                PCWrite = Zero ^ funct3[0];
            end
            C_ST_JAL: begin
                ALUSrcA = C_SRCA_OLDPC;
                ALUSrcB = C_SRCB_FOUR;
                ImmSrc  = C_IMM_J;
                PCWrite = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            C_ST_HALT:     Illegal = 1'b1;
`endif
            default: ;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if ((state_d == C_ST_FETCH) && is_retire_state(state_q)) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= C_ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign InstRet = instret_q;

endmodule

`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

- Moore-style control FSM that sequences a shared-ALU, single-memory multicycle RV32I datapath.
- Decodes the latched instruction and drives every datapath select and write-enable, one state per cycle.
- Keeps a retired-instruction counter for the bench and debug.
- Replaces the combinational single-cycle main decoder when the core moves to the multicycle datapath.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  Instr[6:0] from instruction register
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data write strobe
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = A (rs1)
- ALUSrcB  out  2  00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- RegWrite  out  1  register file write enable
- Illegal  out  1  illegal-opcode halt indicator
- InstRet  out  CNT_W  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, HALT.
- FETCH:
  - AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=1.
  - Next state is DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00; this precomputes the branch target.
  - ImmSrc=10.
  - Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other op → see Configuration.
- MEMADR:
  - ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - ImmSrc=00 for lw (op[5]=0), 01 for sw (op[5]=1).
  - Next state is MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next state is FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next state is FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state is ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, ImmSrc=00. Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next state is FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00.
  - PCWrite = Zero ^ funct3[0], so the block supports both beq and bne.
  - Next state is FETCH.
- JAL:
  - ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1, ImmSrc=11.
  - Next state is ALUWB, which writes PC+4 to rd.
- ALU decoding (ALUOp → ALUControl):
  - 00 → add; 01 → sub.
  - 10 → by funct3: 000 gives sub if funct7b5 & op[5], else add; 010 slt; 110 or; 111 and; 100 xor; other funct3 gives add.
- Default outputs: any output not listed for a state is 0, including all enables. Selects not listed are 00.
- InstRet:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Wraps modulo 2^CNT_W.

## Timing
- Reset:
  - reset asynchronously forces state to FETCH and InstRet to 0.
  - While reset is high, outputs show the FETCH decode. The PC and IR stay reset externally.
  - Leaving reset: the first FETCH is the cycle after the clk edge at which reset is low.
- Outputs are combinational from state, op, funct3, funct7b5 and Zero. There are no output registers.
- Cycles per instruction, FETCH to the next FETCH:
  - lw 5
  - sw 4
  - R-type 4
  - I-type ALU 4
  - branch 3
  - jal 4
- Reset mid-instruction abandons the instruction and does not count it.
- A branch that is taken and a branch that is not taken both take 3 cycles and both count.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An undecoded op in DECODE moves to HALT.
  - HALT holds until reset, with Illegal=1 and all enables 0.
  - The illegal instruction is not counted.
- ILLEGAL_TRAP_EN undefined:
  - DECODE returns to FETCH and the instruction is treated as a NOP.
  - InstRet is not incremented and Illegal is tied 0.
  - The HALT state is absent.

## Structure
- Package mc_pkg holds:
  - the state enum
  - ALUControl constants
  - ResultSrc/ALUSrcA/ALUSrcB/ImmSrc encodings
  - opcode constants.
- One sub-module, alu_decoder, maps (op[5], funct3, funct7b5, ALUOp) to ALUControl.
- The FSM next-state logic and the output decode stay in multicycle_ctrl.

## Test plan
- Release reset, IR = 0x00310233 (add x4,x2,x3):
  - states FETCH, DECODE, EXECUTER, ALUWB
  - ALUControl=000 in EXECUTER, RegWrite=1 only in ALUWB
  - InstRet=1.
- IR = 0x00002103 (lw x2,0(x0)):
  - 5-cycle sequence
  - AdrSrc=1 in MEMREAD, ResultSrc=01 with RegWrite=1 in MEMWB.
- IR = 0x00202223 (sw): MemWrite=1 for exactly one cycle (MEMWRITE) and RegWrite is never 1.
- IR = 0x00000463 (beq): Zero=1 gives PCWrite=1 in BRANCH; Zero=0 gives PCWrite=0; both take 3 cycles.
- IR = 0x0080006F (jal): PCWrite=1 in JAL, then RegWrite=1 with ResultSrc=00.
- op = 0x7F: with ILLEGAL_TRAP_EN, Illegal=1, state held for 10 cycles, and InstRet unchanged. Assert reset mid-HALT: state returns to FETCH and InstRet=0.
